control_unit: RTL and testbench

//   Multi-cycle main control FSM for the 16-bit processor. Decodes the 6-bit opcode and sequences each

---
 rtl/control_unit.sv | 142 ++++++++++++++
 tb/tb_control_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Main control FSM for the 16-bit multi-cycle processor: sequences IF/ID/EX/MEM/WB
// and decodes the live opcode/flags into datapath selects and enables (combinational).
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zeroFlag,
  input  logic       carryFlag,
  input  logic       negFlag,
  output logic [2:0] state,
  output logic [2:0] next_state,
  output logic [1:0] PC_src,
  output logic       ext_src,
  output logic       RegW1,
  output logic       RegW2,
  output logic       read,
  output logic       write,
  output logic       reg_des,
  output logic       ALU_src,
  output logic [1:0] wb_data,
  output logic       j_src
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  state_t nxt;
  logic   unused_carry;
  assign unused_carry = carryFlag;

  logic is_rtype, is_addi, is_andi, is_load, is_store, is_branch;
  logic is_jmp, is_call, is_ret, is_lwpoi, is_pop, is_push, taken;

  assign is_rtype  = (opcode <= 6'd2);
  assign is_addi   = (opcode == 6'd3);
  assign is_andi   = (opcode == 6'd4);
  assign is_lwpoi  = (opcode == 6'd6);
  assign is_pop    = (opcode == 6'd16);
  assign is_load   = (opcode == 6'd5) | is_lwpoi | is_pop;
  assign is_push   = (opcode == 6'd15);
  assign is_store  = (opcode == 6'd7) | is_push;
  assign is_branch = (opcode >= 6'd8) && (opcode <= 6'd11);
  assign is_jmp    = (opcode == 6'd12);
  assign is_call   = (opcode == 6'd13);
  assign is_ret    = (opcode == 6'd14);

  // Branch condition selected by the low two opcode bits: BGT, BLT, BEQ, BNE.
  always_comb begin
    case (opcode[1:0])
      2'b00:   taken = !zeroFlag && !negFlag;
      2'b01:   taken = negFlag;
      2'b10:   taken = zeroFlag;
      default: taken = !zeroFlag;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IF;
    else        state <= next_state;
  end

  assign next_state = nxt;

  always_comb begin
    nxt     = S_IF;
    PC_src  = 2'b11;
    ext_src = 1'b0;
    RegW1   = 1'b0;
    RegW2   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    reg_des = 1'b0;
    ALU_src = 1'b0;
    wb_data = 2'b00;
    j_src   = 1'b0;
    case (state)
      S_IF: nxt = S_ID;
      S_ID: begin
        if (is_rtype || is_addi || is_andi || is_load || is_store || is_branch) begin
          nxt = S_EX;
        end else if (is_jmp || is_call) begin
          PC_src  = 2'b10;
          ext_src = 1'b1;
          if (is_call) begin
            RegW1   = 1'b1;
            reg_des = 1'b1;
            wb_data = 2'b10;
          end
        end else if (is_ret) begin
          PC_src = 2'b10;
          j_src  = 1'b1;
        end else begin
          PC_src = 2'b00;
        end
      end
      S_EX: begin
        if (is_load || is_store) begin
          nxt     = S_MEM;
          ALU_src = 1'b1;
          ext_src = 1'b1;
        end else if (is_branch) begin
          ext_src = 1'b1;
          PC_src  = taken ? 2'b01 : 2'b00;
        end else if (is_rtype || is_addi || is_andi) begin
          nxt     = S_WB;
          ALU_src = is_addi || is_andi;
          ext_src = is_addi;
        end
      end
      S_MEM: begin
        if (is_load) begin
          nxt  = S_WB;
          read = 1'b1;
        end else if (is_store) begin
          write  = 1'b1;
          PC_src = 2'b00;
          RegW2  = is_push;
        end
      end
      S_WB: begin
        // WB always ends the instruction, whatever the opcode has become.
        PC_src = 2'b00;
        if (is_load) begin
          RegW1   = 1'b1;
          wb_data = 2'b01;
          RegW2   = is_lwpoi || is_pop;
        end else if (is_rtype || is_addi || is_andi) begin
          RegW1   = 1'b1;
          ALU_src = is_addi || is_andi;
          ext_src = is_addi;
        end
      end
      default: nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed cases plus random instruction stream against a behavioural model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zeroFlag, carryFlag, negFlag;
  logic [2:0] state, next_state;
  logic [1:0] PC_src, wb_data;
  logic       ext_src, RegW1, RegW2, read, write, reg_des, ALU_src, j_src;
  logic [11:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zeroFlag(zeroFlag),
    .carryFlag(carryFlag), .negFlag(negFlag), .state(state), .next_state(next_state),
    .PC_src(PC_src), .ext_src(ext_src), .RegW1(RegW1), .RegW2(RegW2), .read(read),
    .write(write), .reg_des(reg_des), .ALU_src(ALU_src), .wb_data(wb_data), .j_src(j_src)
  );

  always #5 clk = ~clk;

  assign outs = {PC_src, ext_src, RegW1, RegW2, read, write, reg_des, ALU_src, wb_data, j_src};

  localparam logic [11:0] IDLE_OUTS = 12'hC00;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Phase lists per instruction class: 0=IF 1=ID 2=EX 3=MEM 4=WB.
  function automatic void phases(input logic [5:0] op, output int seq[$]);
    if (op <= 6'd4)                                seq = '{0, 1, 2, 4};
    else if (op == 6'd5 || op == 6'd6 || op == 6'd16) seq = '{0, 1, 2, 3, 4};
    else if (op == 6'd7 || op == 6'd15)            seq = '{0, 1, 2, 3};
    else if (op >= 6'd8 && op <= 6'd11)            seq = '{0, 1, 2};
    else                                           seq = '{0, 1};
  endfunction

  function automatic logic [11:0] model(input logic [5:0] op, input int ph, input bit last,
                                        input bit z, input bit n);
    logic [1:0] pc, wb;
    bit ext, w1, w2, rd, wr, rdes, alu, js, tk;
    pc = last ? 2'b00 : 2'b11;
    wb = 2'b00;
    {ext, w1, w2, rd, wr, rdes, alu, js} = '0;
    if (op >= 6'd8 && op <= 6'd11 && ph == 2) begin
      case (op)
        6'd8:    tk = !z && !n;
        6'd9:    tk = n;
        6'd10:   tk = z;
        default: tk = !z;
      endcase
      ext = 1;
      pc  = tk ? 2'b01 : 2'b00;
    end
    if (op <= 6'd4 && ph == 4) w1 = 1;
    if ((op == 6'd3 || op == 6'd4) && (ph == 2 || ph == 4)) begin
      alu = 1;
      ext = (op == 6'd3);
    end
    if (op == 6'd5 || op == 6'd6 || op == 6'd16) begin
      if (ph == 2) begin alu = 1; ext = 1; end
      if (ph == 3) rd = 1;
      if (ph == 4) begin w1 = 1; wb = 2'b01; w2 = (op != 6'd5); end
    end
    if (op == 6'd7 || op == 6'd15) begin
      if (ph == 2) begin alu = 1; ext = 1; end
      if (ph == 3) begin wr = 1; w2 = (op == 6'd15); end
    end
    if (op >= 6'd12 && op <= 6'd14 && ph == 1) begin
      pc  = 2'b10;
      ext = (op != 6'd14);
      js  = (op == 6'd14);
      if (op == 6'd13) begin w1 = 1; rdes = 1; wb = 2'b10; end
    end
    return {pc, ext, w1, w2, rd, wr, rdes, alu, wb, js};
  endfunction

  // Entered and left just after a falling edge with the DUT in IF.
  // zf/nf < 0 means random flag each cycle; rst_ex asserts reset while in EX.
  task automatic run_instr(input logic [5:0] op, input int zf, input int nf, input bit rst_ex);
    int seq[$];
    int nxt;
    phases(op, seq);
    opcode = op;
    for (int i = 0; i < seq.size(); i++) begin
      zeroFlag  = (zf < 0) ? 1'($urandom_range(1)) : 1'(zf);
      negFlag   = (nf < 0) ? 1'($urandom_range(1)) : 1'(nf);
      carryFlag = 1'($urandom_range(1));
      #1;
      nxt = (i + 1 < seq.size()) ? seq[i+1] : 0;
      chk("state", 16'(state), 16'(seq[i]));
      chk("next_state", 16'(next_state), 16'(nxt));
      chk("outs", 16'(outs), 16'(model(op, seq[i], i + 1 == seq.size(), zeroFlag, negFlag)));
      if (rst_ex && seq[i] == 2) begin
        rst_n = 1'b0;
        #1;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_outs", 16'(outs), 16'(IDLE_OUTS));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] op;
    rst_n = 1'b0; opcode = 6'd0; zeroFlag = 0; carryFlag = 0; negFlag = 0;
    #1;
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_outs", 16'(outs), 16'(IDLE_OUTS));
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'd1, -1, -1, 0);   // ADD
    run_instr(6'd5, -1, -1, 0);   // LW
    run_instr(6'd7, -1, -1, 0);   // SW
    run_instr(6'd10, 1, 0, 0);    // BEQ taken
    run_instr(6'd10, 0, 0, 0);    // BEQ not taken
    run_instr(6'd9, 0, 1, 0);     // BLT taken
    run_instr(6'd11, 0, 0, 0);    // BNE taken
    run_instr(6'd8, 0, 0, 0);     // BGT taken
    run_instr(6'd8, 1, 0, 0);     // BGT not taken
    run_instr(6'd13, -1, -1, 0);  // CALL
    run_instr(6'd14, -1, -1, 0);  // RET
    run_instr(6'd63, -1, -1, 0);  // NOP
    run_instr(6'd1, -1, -1, 1);   // reset mid-EX
    run_instr(6'd6, -1, -1, 0);   // LW.POI
    run_instr(6'd15, -1, -1, 0);  // PUSH
    run_instr(6'd16, -1, -1, 0);  // POP

    // Illegal state code recovers to IF.
    force dut.state = 3'b101;
    #1;
    chk("illegal_next", 16'(next_state), 16'd0);
    chk("illegal_outs", 16'(outs), 16'(IDLE_OUTS));
    release dut.state;
    @(negedge clk);
    chk("illegal_recover", 16'(state), 16'd0);

    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(9) < 7) ? 6'($urandom_range(16)) : 6'($urandom);
      run_instr(op, -1, -1, ($urandom_range(19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
